// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI frame constants and state encoding
package spi_pkg;

    localparam int FRAME_W = 10;
    localparam int CNT_W   = 4;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        SEL,
        SHIFT,
        WAIT,
        RECV,
        END
    } spi_state_t;

endpackage

// File: rtl/spi_shreg.sv
// rtl/spi_shreg.sv - parallel-load shift register, MSB out, serial-in at LSB
module spi_shreg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_data,
    input  logic         i_shift,
    input  logic         i_sin,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_data;
        end else if (i_shift) begin
            r_q <= {r_q[W-2:0], i_sin};
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - SPI master framing host commands for the FSM_SPI slave
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int RD_WAIT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        cmd,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              MOSI,
    input  logic              MISO,
    output logic              ss_n
);

    localparam int TX_W = 2 + DATA_W;

    spi_state_t        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_is_read;
    logic              r_ss_n;
    logic              r_busy;
    logic              r_done;
    logic              r_rdata_valid;
    logic [DATA_W-1:0] r_rdata;

    logic              w_accept;
    logic [TX_W-1:0]   w_tx_q;
    logic [DATA_W-1:0] w_rx_q;
    logic              w_tx_unused;
    logic              w_rx_unused;

    assign w_accept = (r_state == IDLE) && start;

    // TX shifts with zero fill, so its MSB is 0 once the frame is out and
    // can drive MOSI directly in every state.
    spi_shreg #(.W(TX_W)) u_tx (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_accept),
        .i_data  ({cmd, wdata}),
        .i_shift (r_state == SHIFT),
        .i_sin   (1'b0),
        .o_q     (w_tx_q)
    );

    spi_shreg #(.W(DATA_W)) u_rx (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (1'b0),
        .i_data  ('0),
        .i_shift (r_state == RECV),
        .i_sin   (MISO),
        .o_q     (w_rx_q)
    );

    assign w_tx_unused = &{1'b0, w_tx_q[TX_W-2:0]};
    assign w_rx_unused = &{1'b0, w_rx_q[DATA_W-1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_is_read     <= 1'b0;
            r_ss_n        <= 1'b1;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_rdata_valid <= 1'b0;
            r_rdata       <= '0;
        end else begin
            r_done        <= 1'b0;
            r_rdata_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state   <= SEL;
                        r_is_read <= (cmd == CMD_RD_DATA);
                        r_ss_n    <= 1'b0;
                        r_busy    <= 1'b1;
                    end
                end
                SEL: begin
                    r_state <= SHIFT;
                    r_cnt   <= CNT_W'(TX_W - 1);
                end
                SHIFT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (r_is_read) begin
                        r_state <= WAIT;
                        r_cnt   <= CNT_W'(RD_WAIT - 1);
                    end else begin
                        r_state <= END;
                        r_ss_n  <= 1'b1;
                        r_done  <= 1'b1;
                    end
                end
                WAIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_state <= RECV;
                        r_cnt   <= CNT_W'(DATA_W - 1);
                    end
                end
                RECV: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        // Final MISO bit lands in rdata on the same edge as the rx shift.
                        r_rdata       <= {w_rx_q[DATA_W-2:0], MISO};
                        r_state       <= END;
                        r_ss_n        <= 1'b1;
                        r_done        <= 1'b1;
                        r_rdata_valid <= 1'b1;
                    end
                end
                END: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_ss_n  <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign rdata       = r_rdata;
    assign rdata_valid = r_rdata_valid;
    assign MOSI        = w_tx_q[TX_W-1];
    assign ss_n        = r_ss_n;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb/tb_spi_master_ctrl.sv - directed self-checking bench for spi_master_ctrl
module tb_spi_master_ctrl;

    localparam int DATA_W  = 8;
    localparam int RD_WAIT = 2;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [1:0]        cmd;
    logic [DATA_W-1:0] wdata;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rdata;
    logic              rdata_valid;
    logic              MOSI;
    logic              MISO;
    logic              ss_n;

    int n_checks = 0;
    int n_fail   = 0;

    spi_master_ctrl #(.DATA_W(DATA_W), .RD_WAIT(RD_WAIT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .cmd         (cmd),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .MOSI        (MOSI),
        .MISO        (MISO),
        .ss_n        (ss_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Acts as the slave: records MOSI after the SEL bit, serves reply on MISO in the RECV window.
    task automatic run_frame(input logic [1:0] c, input logic [7:0] d, input logic [7:0] reply,
                             output int low_cycles, output logic [9:0] rx_bits,
                             output int done_at, output int rv_at, output logic [7:0] rd_at_done);
        int lo;
        lo = 11 + RD_WAIT;
        low_cycles = 0;
        rx_bits    = '0;
        done_at    = -1;
        rv_at      = -1;
        rd_at_done = '0;
        @(negedge clk);
        start = 1'b1;
        cmd   = c;
        wdata = d;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (ss_n == 1'b0) begin
                low_cycles++;
                if (k >= 1 && k <= 10) rx_bits = {rx_bits[8:0], MOSI};
            end
            if (rdata_valid) rv_at = k + 1;
            if (k >= lo && k < lo + 8) MISO = reply[7 - (k - lo)];
            else                       MISO = ~reply[k % 8];
            if (done) begin
                done_at    = k + 1;
                rd_at_done = rdata;
                break;
            end
            @(negedge clk);
        end
        MISO = 1'b0;
    endtask

    task automatic test_reset;
        logic held_ok;
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (ss_n !== 1'b1 || MOSI !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rdata_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ss_n=%b MOSI=%b busy=%b done=%b rv=%b want 1 0 0 0 0",
                     ss_n, MOSI, busy, done, rdata_valid);
        end
        n_checks++;
        if (rdata !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h want 00", rdata);
        end
        rst_n   = 1'b1;
        held_ok = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (ss_n !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || MOSI !== 1'b0) held_ok = 1'b0;
        end
        n_checks++;
        if (held_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_hold: got activity with start=0 want none");
        end
    endtask

    task automatic test_write_addr;
        int lc, da, rv;
        logic [9:0] rx;
        logic [7:0] rd;
        run_frame(2'b00, 8'hA5, 8'h00, lc, rx, da, rv, rd);
        n_checks++;
        if (lc != 11) begin n_fail++; $display("FAIL wa_ss_low: got %0d want 11", lc); end
        n_checks++;
        if (rx !== 10'b0010100101) begin n_fail++; $display("FAIL wa_mosi: got %b want 0010100101", rx); end
        n_checks++;
        if (da != 12) begin n_fail++; $display("FAIL wa_done_lat: got %0d want 12", da); end
        n_checks++;
        if (rv != -1) begin n_fail++; $display("FAIL wa_rvalid: got %0d want -1", rv); end
    endtask

    task automatic test_write_data;
        int lc, da, rv;
        logic [9:0] rx;
        logic [7:0] rd;
        run_frame(2'b01, 8'h3C, 8'h00, lc, rx, da, rv, rd);
        n_checks++;
        if (rx !== 10'b0100111100) begin n_fail++; $display("FAIL wd_rx: got %b want 0100111100", rx); end
        n_checks++;
        if (da != 12) begin n_fail++; $display("FAIL wd_done: got %0d want 12", da); end
    endtask

    task automatic test_read;
        int lc, da, rv;
        logic [9:0] rx;
        logic [7:0] rd;
        run_frame(2'b10, 8'h12, 8'h00, lc, rx, da, rv, rd);
        n_checks++;
        if (rx !== 10'b1000010010 || lc != 11) begin
            n_fail++;
            $display("FAIL ra_frame: got %b/%0d want 1000010010/11", rx, lc);
        end
        run_frame(2'b11, 8'hFF, 8'hC3, lc, rx, da, rv, rd);
        n_checks++;
        if (rx !== 10'b1111111111) begin n_fail++; $display("FAIL rd_mosi: got %b want 1111111111", rx); end
        n_checks++;
        if (lc != 11 + RD_WAIT + 8) begin n_fail++; $display("FAIL rd_ss_low: got %0d want %0d", lc, 11 + RD_WAIT + 8); end
        n_checks++;
        if (rd !== 8'hC3) begin n_fail++; $display("FAIL rd_data: got %h want c3", rd); end
        n_checks++;
        if (da != 12 + RD_WAIT + 8 || rv != da) begin
            n_fail++;
            $display("FAIL rd_valid_timing: got done=%0d rv=%0d want both %0d", da, rv, 12 + RD_WAIT + 8);
        end
    endtask

    task automatic test_back_to_back;
        int n_done, done_k, lc;
        logic gap_ok;
        n_done = 0;
        done_k = -1;
        lc     = 0;
        gap_ok = 1'b1;
        @(negedge clk);
        start = 1'b1;
        cmd   = 2'b00;
        wdata = 8'h55;
        @(posedge clk);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            start = (k == 5 || k == 11);
            if (ss_n == 1'b0) lc++;
            if (done) begin n_done++; done_k = k; end
            if (k >= 11 && ss_n !== 1'b1) gap_ok = 1'b0;
        end
        start = 1'b0;
        n_checks++;
        if (n_done != 1 || done_k != 11) begin
            n_fail++;
            $display("FAIL b2b_done: got count=%0d at=%0d want 1 at 11", n_done, done_k);
        end
        n_checks++;
        if (lc != 11) begin n_fail++; $display("FAIL b2b_ss_low: got %0d want 11", lc); end
        n_checks++;
        if (gap_ok !== 1'b1) begin n_fail++; $display("FAIL b2b_ss_gap: got ss_n low after END want high"); end
        n_checks++;
        if (rdata !== 8'hC3) begin n_fail++; $display("FAIL rdata_hold: got %h want c3", rdata); end
    endtask

    task automatic test_reset_mid_frame;
        int lc, da, rv;
        logic [9:0] rx;
        logic [7:0] rd;
        logic quiet;
        @(negedge clk);
        start = 1'b1;
        cmd   = 2'b01;
        wdata = 8'hF0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (ss_n !== 1'b1 || busy !== 1'b0 || MOSI !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_async: got ss_n=%b busy=%b MOSI=%b want 1 0 0", ss_n, busy, MOSI);
        end
        n_checks++;
        if (rdata !== 8'h00) begin n_fail++; $display("FAIL mid_reset_rdata: got %h want 00", rdata); end
        quiet = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done !== 1'b0 || rdata_valid !== 1'b0) quiet = 1'b0;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done !== 1'b0 || rdata_valid !== 1'b0 || ss_n !== 1'b1) quiet = 1'b0;
        end
        n_checks++;
        if (quiet !== 1'b1) begin n_fail++; $display("FAIL mid_reset_quiet: got pulse or select want none"); end
        run_frame(2'b11, 8'h00, 8'h5A, lc, rx, da, rv, rd);
        n_checks++;
        if (rd !== 8'h5A || rx !== 10'b1100000000 || lc != 11 + RD_WAIT + 8 || rv != da) begin
            n_fail++;
            $display("FAIL post_reset_frame: got rd=%h rx=%b low=%0d rv=%0d done=%0d want 5a 1100000000 %0d equal",
                     rd, rx, lc, rv, da, 11 + RD_WAIT + 8);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        cmd   = 2'b00;
        wdata = '0;
        MISO  = 1'b0;
        test_reset();
        test_write_addr();
        test_write_data();
        test_read();
        test_back_to_back();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
